// File: rtl/ro_pair_compare.sv
// rtl/ro_pair_compare.sv - RO-PUF pair comparator: enables two ROs, counts edges over a window, emits response bit.
// Optional PUF_MARGIN_EN adds the unreliable output (|count_a-count_b| < MARGIN).
module ro_pair_compare #(
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1024,
  parameter int SETTLE = 16
`ifdef PUF_MARGIN_EN
  ,
  parameter int MARGIN = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             ro_enable,
  output logic             busy,
  output logic             done,
  output logic             response,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
`ifdef PUF_MARGIN_EN
  ,
  output logic             unreliable
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_COMPARE,
    S_DONE
  } state_t;

  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t r_state;
  state_t w_next;

  logic [TMR_W-1:0] r_timer;
  logic [2:0]       r_sync_a;
  logic [2:0]       r_sync_b;
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;

  logic w_rise_a;
  logic w_rise_b;
  logic w_settle_end;
  logic w_window_end;
  logic w_sat_a;
  logic w_sat_b;

  // [1] is the second synchroniser flop, [2] the edge-detect history flop.
  assign w_rise_a     = r_sync_a[1] & ~r_sync_a[2];
  assign w_rise_b     = r_sync_b[1] & ~r_sync_b[2];
  assign w_settle_end = (r_state == S_SETTLE)  && (r_timer == TMR_W'(SETTLE - 1));
  assign w_window_end = (r_state == S_MEASURE) && (r_timer == TMR_W'(WINDOW - 1));
  assign w_sat_a      = (r_cnt_a == {CNT_W{1'b1}});
  assign w_sat_b      = (r_cnt_b == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    ro_enable = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_SETTLE;
      end
      S_SETTLE: begin
        ro_enable = 1'b1;
        busy      = 1'b1;
        if (w_settle_end) w_next = S_MEASURE;
      end
      S_MEASURE: begin
        ro_enable = 1'b1;
        busy      = 1'b1;
        if (w_window_end) w_next = S_COMPARE;
      end
      S_COMPARE: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_a <= 3'b000;
      r_sync_b <= 3'b000;
    end else begin
      r_sync_a <= {r_sync_a[1:0], ro_a};
      r_sync_b <= {r_sync_b[1:0], ro_b};
    end
  end

  // Timer restarts at each phase boundary so SETTLE and MEASURE share it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= '0;
    end else if (r_state == S_IDLE || w_settle_end || w_window_end) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (r_state == S_MEASURE) begin
      if (w_rise_a && !w_sat_a) r_cnt_a <= r_cnt_a + 1'b1;
      if (w_rise_b && !w_sat_b) r_cnt_b <= r_cnt_b + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_a  <= '0;
      count_b  <= '0;
      response <= 1'b0;
    end else if (r_state == S_COMPARE) begin
      count_a  <= r_cnt_a;
      count_b  <= r_cnt_b;
      response <= (r_cnt_a > r_cnt_b);
    end
  end

`ifdef PUF_MARGIN_EN
  localparam int DW = CNT_W + 1;

  logic [DW-1:0] w_abs_diff;

  assign w_abs_diff = (r_cnt_a >= r_cnt_b) ? ({1'b0, r_cnt_a} - {1'b0, r_cnt_b})
                                           : ({1'b0, r_cnt_b} - {1'b0, r_cnt_a});

  always_ff @(posedge clk) begin
    if (reset) begin
      unreliable <= 1'b0;
    end else if (r_state == S_COMPARE) begin
      unreliable <= (w_abs_diff < DW'(MARGIN));
    end
  end
`endif

endmodule

// File: tb/tb_ro_pair_compare.sv
// tb/tb_ro_pair_compare.sv - directed vector bench for ro_pair_compare.
module tb_ro_pair_compare;

  localparam int WIN = 100;
  localparam int SET = 4;
  // Observed #1 after edges following the start edge: done appears after edge SET+WIN+1.
  localparam int LAT = SET + WIN + 1;

  logic        clk;
  logic        reset;
  logic        start;
  logic        ro_a0, ro_b0, ro_a1, ro_b1;
  logic        ro_en0, busy0, done0, resp0;
  logic        ro_en1, busy1, done1, resp1;
  logic [15:0] cnt_a0, cnt_b0;
  logic [3:0]  cnt_a1, cnt_b1;
`ifdef PUF_MARGIN_EN
  logic        unrel0, unrel1;
`endif

  int checks = 0;
  int failures = 0;
  int per_a = 0;
  int per_b = 0;
  int ph = 0;

  ro_pair_compare #(.CNT_W(16), .WINDOW(WIN), .SETTLE(SET)) dut0 (
    .clk(clk), .reset(reset), .start(start), .ro_a(ro_a0), .ro_b(ro_b0),
    .ro_enable(ro_en0), .busy(busy0), .done(done0), .response(resp0),
    .count_a(cnt_a0), .count_b(cnt_b0)
`ifdef PUF_MARGIN_EN
    , .unreliable(unrel0)
`endif
  );

  ro_pair_compare #(.CNT_W(4), .WINDOW(WIN), .SETTLE(SET)) dut1 (
    .clk(clk), .reset(reset), .start(start), .ro_a(ro_a1), .ro_b(ro_b1),
    .ro_enable(ro_en1), .busy(busy1), .done(done1), .response(resp1),
    .count_a(cnt_a1), .count_b(cnt_b1)
`ifdef PUF_MARGIN_EN
    , .unreliable(unrel1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator models: rise once every per_x clk cycles, changing on the falling edge.
  initial begin
    ro_a0 = 1'b0; ro_b0 = 1'b0; ro_a1 = 1'b0; ro_b1 = 1'b0;
  end
  always @(negedge clk) begin
    ro_a0 = (per_a != 0) && ((ph % (per_a == 0 ? 1 : per_a)) < per_a / 2);
    ro_b0 = (per_b != 0) && ((ph % (per_b == 0 ? 1 : per_b)) < per_b / 2);
    ro_a1 = ((ph % 2) == 0);
    ro_b1 = 1'b0;
    ph = ph + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  typedef struct {
    int   pa;
    int   pb;
    int   a_lo;
    int   a_hi;
    int   b_lo;
    int   b_hi;
    logic resp;
    logic unrel;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int cyc;
    int nd;
    int d1;
    int d2;

    vecs[0] = '{pa: 4, pb: 6, a_lo: 25, a_hi: 25, b_lo: 16, b_hi: 17, resp: 1'b1, unrel: 1'b0};
    vecs[1] = '{pa: 6, pb: 4, a_lo: 16, a_hi: 17, b_lo: 25, b_hi: 25, resp: 1'b0, unrel: 1'b0};
    vecs[2] = '{pa: 5, pb: 5, a_lo: 20, a_hi: 20, b_lo: 20, b_hi: 20, resp: 1'b0, unrel: 1'b1};
    vecs[3] = '{pa: 2, pb: 0, a_lo: 50, a_hi: 50, b_lo: 0,  b_hi: 0,  resp: 1'b1, unrel: 1'b0};
    vecs[4] = '{pa: 0, pb: 3, a_lo: 0,  a_hi: 0,  b_lo: 33, b_hi: 34, resp: 1'b0, unrel: 1'b0};

    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ro_enable", ro_en0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_response", resp0, 0);
    chk("rst_count_a", cnt_a0, 0);
    chk("rst_count_b", cnt_b0, 0);
    chk("rst_sat_count_a", cnt_a1, 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      per_a = vecs[i].pa;
      per_b = vecs[i].pb;
      repeat (8) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 0;
      chk($sformatf("v%0d_busy_first", i), busy0, 1);
      chk($sformatf("v%0d_ro_enable_first", i), ro_en0, 1);
      while (!done0 && cyc < 400) begin
        if (cyc == LAT - 1) begin
          chk($sformatf("v%0d_ro_enable_compare", i), ro_en0, 0);
          chk($sformatf("v%0d_busy_compare", i), busy0, 1);
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      chk($sformatf("v%0d_latency", i), cyc, LAT);
      chk($sformatf("v%0d_busy_at_done", i), busy0, 0);
      chk_rng($sformatf("v%0d_count_a", i), cnt_a0, vecs[i].a_lo, vecs[i].a_hi);
      chk_rng($sformatf("v%0d_count_b", i), cnt_b0, vecs[i].b_lo, vecs[i].b_hi);
      chk($sformatf("v%0d_response", i), resp0, vecs[i].resp);
`ifdef PUF_MARGIN_EN
      chk($sformatf("v%0d_unreliable", i), unrel0, vecs[i].unrel);
`endif
      chk($sformatf("v%0d_sat_done", i), done1, 1);
      chk($sformatf("v%0d_sat_count_a", i), cnt_a1, 15);
      chk($sformatf("v%0d_sat_count_b", i), cnt_b1, 0);
      chk($sformatf("v%0d_sat_response", i), resp1, 1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_one_cycle", i), done0, 0);
      chk($sformatf("v%0d_count_a_held", i) , (cnt_a0 >= vecs[i].a_lo && cnt_a0 <= vecs[i].a_hi) ? 1 : 0, 1);
    end

    // Reset in the middle of MEASURE aborts with no done pulse.
    per_a = 4;
    per_b = 6;
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("mid_ro_enable_before", ro_en0, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_ro_enable", ro_en0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_done", done0, 0);
    chk("mid_rst_count_a", cnt_a0, 0);
    chk("mid_rst_count_b", cnt_b0, 0);
    reset = 1'b0;
    nd = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (done0) nd++;
    end
    chk("mid_rst_no_done", nd, 0);

    // start pulses during SETTLE and MEASURE are ignored.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    nd = 0;
    d1 = -1;
    while (cyc < 300) begin
      start = (cyc == 2 || cyc == 50);
      @(posedge clk);
      #1;
      cyc++;
      if (done0) begin
        nd++;
        if (nd == 1) d1 = cyc;
      end
    end
    start = 1'b0;
    chk("ign_done_count", nd, 1);
    chk("ign_done_latency", d1, LAT);

    // start held high: back-to-back runs with a single IDLE cycle between them.
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    nd = 0;
    d1 = -10;
    d2 = -10;
    while (nd < 2 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done0) begin
        if (nd == 0) d1 = cyc;
        else d2 = cyc;
        nd++;
      end
      if (nd == 1 && cyc == d1 + 1) chk("hold_idle_busy", busy0, 0);
      if (nd == 1 && cyc == d1 + 2) chk("hold_rebusy", busy0, 1);
    end
    start = 1'b0;
    chk("hold_first_done", d1, LAT);
    chk("hold_done_spacing", d2 - d1, LAT + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
